// File: rtl/tap_delay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tap_delay_pkg
// Description : Shared types and default constants for the tap delay
//               detector: FSM state encoding and default stream width,
//               maximum delay, lock and loss thresholds.
// Revision    : 1.0 - initial release
// ============================================================================
package tap_delay_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_DEPTH      = 3;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_LOSS_COUNT = 2;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tap_run_counter.sv
`default_nettype none
// ============================================================================
// Module      : tap_run_counter
// Description : Saturating consecutive-match counter for one candidate tap.
//               Counts valid samples that match, clears on a valid mismatch
//               or on i_clear, and holds while i_valid is low.
// Ports       : clk      - clock
//               areset   - asynchronous active-high reset
//               i_valid  - a new sample is present
//               i_match  - this tap matches the current sample
//               i_clear  - force the run back to zero
//               o_hit    - run reaches LOCK_COUNT on this sample
// Revision    : 1.0 - initial release
// ============================================================================
module tap_run_counter
    import tap_delay_pkg::*;
#(
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int CW         = $clog2(LOCK_COUNT + 1)
) (
    input  logic clk,
    input  logic areset,
    input  logic i_valid,
    input  logic i_match,
    input  logic i_clear,
    output logic o_hit
);

    localparam logic [CW-1:0] C_MAX = CW'(LOCK_COUNT);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_next;

    always_comb begin
        w_next = r_count;
        if (i_clear) begin
            w_next = '0;
        end else if (i_valid) begin
            if (i_match) begin
                w_next = (r_count == C_MAX) ? r_count : r_count + 1'b1;
            end else begin
                w_next = '0;
            end
        end
    end

    // A hit means this very sample leaves the run at the threshold.
    assign o_hit = i_valid && i_match && !i_clear && (w_next == C_MAX);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tap_delay_detector.sv
`default_nettype none
// ============================================================================
// Module      : tap_delay_detector
// Description : Recovers the delay applied by a tapped delay line by
//               comparing its output stream against a local history of its
//               input stream for every candidate delay 0..DEPTH.
// Ports       : clk    - clock, rising edge
//               areset - asynchronous active-high reset
//               valid  - d/q carry a new sample
//               d      - delay-line input sample
//               q      - delay-line output sample
//               locked - registered, sel is trustworthy
//               sel    - registered, detected delay
//               lost   - registered one-cycle pulse when lock drops
// Revision    : 1.0 - initial release
// ============================================================================
module tap_delay_detector
    import tap_delay_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int LOSS_COUNT = DEF_LOSS_COUNT,
    parameter int SW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             valid,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] q,
    output logic             locked,
    output logic [SW-1:0]    sel,
    output logic             lost
);

    localparam int            MW      = $clog2(LOSS_COUNT + 1);
    localparam logic [SW-1:0] C_DEPTH = SW'(DEPTH);
    localparam logic [MW-1:0] C_LAST  = MW'(LOSS_COUNT - 1);

    logic [WIDTH-1:0] r_hist [1:DEPTH];
    logic [WIDTH-1:0] w_tap  [0:DEPTH];
    logic [SW-1:0]    r_fill;
    logic [MW-1:0]    r_miss;
    state_t           r_state;
    logic             r_locked;
    logic [SW-1:0]    r_sel;
    logic             r_lost;

    logic [DEPTH:0]   w_match;
    logic [DEPTH:0]   w_hit;
    logic             w_any_hit;
    logic [SW-1:0]    w_first;
    logic             w_sel_match;
    logic             w_drop;

    // Tap 0 is the live input; deeper taps come from the history.
    assign w_tap[0] = d;

    generate
        for (genvar k = 1; k <= DEPTH; k++) begin : g_tap_hist
            assign w_tap[k] = r_hist[k];
        end

        for (genvar k = 0; k <= DEPTH; k++) begin : g_tap
            // Tap k only holds real data once k samples have been seen.
            assign w_match[k] = (r_fill >= SW'(k)) && (q == w_tap[k]);

            tap_run_counter #(
                .LOCK_COUNT (LOCK_COUNT)
            ) u_run (
                .clk     (clk),
                .areset  (areset),
                .i_valid (valid),
                .i_match (w_match[k]),
                .i_clear (w_drop),
                .o_hit   (w_hit[k])
            );
        end
    endgenerate

    // Lowest-index priority: scan downwards so the smallest hit wins.
    always_comb begin
        w_any_hit = 1'b0;
        w_first   = '0;
        for (int k = DEPTH; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_any_hit = 1'b1;
                w_first   = SW'(k);
            end
        end
    end

    assign w_sel_match = w_match[r_sel];
    assign w_drop      = (r_state == LOCK) && valid && !w_sel_match &&
                         (r_miss == C_LAST);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_hist[k] <= '0;
            end
            r_fill <= '0;
        end else if (valid) begin
            r_hist[1] <= d;
            for (int k = 2; k <= DEPTH; k++) begin
                r_hist[k] <= r_hist[k-1];
            end
            if (r_fill != C_DEPTH) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
            r_sel    <= '0;
            r_lost   <= 1'b0;
            r_miss   <= '0;
        end else begin
            r_lost <= 1'b0;
            if (valid) begin
                case (r_state)
                    SEARCH: begin
                        if (w_any_hit) begin
                            r_state  <= LOCK;
                            r_locked <= 1'b1;
                            r_sel    <= w_first;
                            r_miss   <= '0;
                        end
                    end
                    LOCK: begin
                        if (w_sel_match) begin
                            r_miss <= '0;
                        end else if (w_drop) begin
                            // sel keeps its last value for post-mortem use.
                            r_state  <= SEARCH;
                            r_locked <= 1'b0;
                            r_lost   <= 1'b1;
                            r_miss   <= '0;
                        end else begin
                            r_miss <= r_miss + 1'b1;
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
        end
    end

    assign locked = r_locked;
    assign sel    = r_sel;
    assign lost   = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_tap_delay_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_tap_delay_detector
// Description : Directed self-checking bench for tap_delay_detector. A
//               behavioural delay line produces q; expected outputs for each
//               cycle are queued when stimulus is driven and compared after
//               the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tap_delay_detector;
    import tap_delay_pkg::*;

    logic       clk = 1'b0;
    logic       areset;
    logic       valid;
    logic [7:0] d;
    logic [7:0] q;
    logic       locked;
    logic [1:0] sel;
    logic       lost;

    always #5 clk = ~clk;

    tap_delay_detector #(
        .WIDTH      (8),
        .DEPTH      (3),
        .LOCK_COUNT (4),
        .LOSS_COUNT (2),
        .SW         (2)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .valid  (valid),
        .d      (d),
        .q      (q),
        .locked (locked),
        .sel    (sel),
        .lost   (lost)
    );

    typedef struct packed {
        logic       lk;
        logic [1:0] sl;
        logic       ls;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;

    // Behavioural delay line: bh[i] is the input i valid samples ago.
    logic [7:0] bh [1:3];
    int         bcnt;

    task automatic line_clear();
        for (int i = 1; i <= 3; i++) bh[i] = 8'h00;
        bcnt = 0;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            total++;
            assert (locked === e.lk) else begin
                bad++;
                $error("FAIL %s.locked observed=%0b expected=%0b", tag, locked, e.lk);
            end
            total++;
            assert (sel === e.sl) else begin
                bad++;
                $error("FAIL %s.sel observed=%0d expected=%0d", tag, sel, e.sl);
            end
            total++;
            assert (lost === e.ls) else begin
                bad++;
                $error("FAIL %s.lost observed=%0b expected=%0b", tag, lost, e.ls);
            end
        end
    endtask

    // One valid sample through a line of delay dly (q forced to 0xFF when corrupt).
    task automatic vsample(input logic [7:0] dv, input int dly, input logic corrupt,
                           input logic el, input logic [1:0] es, input logic elost,
                           input string tag);
        logic [7:0] qv;
        if (dly == 0)        qv = dv;
        else if (bcnt >= dly) qv = bh[dly];
        else                 qv = 8'h00;
        if (corrupt) qv = 8'hFF;
        valid = 1'b1;
        d     = dv;
        q     = qv;
        sb.push_back('{lk: el, sl: es, ls: elost});
        @(posedge clk);
        bh[3] = bh[2];
        bh[2] = bh[1];
        bh[1] = dv;
        bcnt++;
        #1;
        check_out(tag);
    endtask

    task automatic idle(input logic el, input logic [1:0] es, input logic elost,
                        input string tag);
        valid = 1'b0;
        d     = 8'($urandom);
        q     = 8'($urandom);
        sb.push_back('{lk: el, sl: es, ls: elost});
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    // Reset asserted away from a clock edge; outputs must clear at once.
    task automatic do_reset(input string tag);
        valid  = 1'b0;
        areset = 1'b1;
        #2;
        total++;
        assert (locked === 1'b0) else begin
            bad++;
            $error("FAIL %s.locked observed=%0b expected=0", tag, locked);
        end
        total++;
        assert (sel === 2'd0) else begin
            bad++;
            $error("FAIL %s.sel observed=%0d expected=0", tag, sel);
        end
        total++;
        assert (lost === 1'b0) else begin
            bad++;
            $error("FAIL %s.lost observed=%0b expected=0", tag, lost);
        end
        @(posedge clk);
        #1;
        areset = 1'b0;
        line_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        valid  = 1'b0;
        d      = 8'h00;
        q      = 8'h00;
        line_clear();
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('{lk: 1'b0, sl: 2'd0, ls: 1'b0});
        check_out("reset");
        areset = 1'b0;

        // Delay 2, incrementing data: lock after sample 6 with sel=2.
        for (int i = 1; i <= 8; i++)
            vsample(8'(i), 2, 1'b0, (i >= 6), (i >= 6) ? 2'd2 : 2'd0, 1'b0,
                    $sformatf("d2_s%0d", i));

        // Line switches to delay 1: two misses drop lock, then relock on tap 1.
        vsample(8'd9,  1, 1'b0, 1'b1, 2'd2, 1'b0, "sw_m1");
        vsample(8'd10, 1, 1'b0, 1'b0, 2'd2, 1'b1, "sw_m2");
        idle(1'b0, 2'd2, 1'b0, "sw_idle");
        for (int i = 11; i <= 15; i++)
            vsample(8'(i), 1, 1'b0, (i >= 14), (i >= 14) ? 2'd1 : 2'd2, 1'b0,
                    $sformatf("sw_s%0d", i));

        // Reset while locked, then delay 1 with valid toggling.
        do_reset("rst1");
        for (int i = 1; i <= 5; i++) begin
            vsample(8'(i), 1, 1'b0, (i >= 5), (i >= 5) ? 2'd1 : 2'd0, 1'b0,
                    $sformatf("tog_s%0d", i));
            idle((i >= 5), (i >= 5) ? 2'd1 : 2'd0, 1'b0, $sformatf("tog_i%0d", i));
        end

        // Reset while locked, delay 3 needs 7 valid samples from scratch.
        do_reset("rst2");
        for (int i = 1; i <= 8; i++)
            vsample(8'(i), 3, 1'b0, (i >= 7), (i >= 7) ? 2'd3 : 2'd0, 1'b0,
                    $sformatf("d3_s%0d", i));

        // Isolated corrupt samples never accumulate into a loss.
        vsample(8'd9,  3, 1'b1, 1'b1, 2'd3, 1'b0, "glitch_9");
        vsample(8'd10, 3, 1'b0, 1'b1, 2'd3, 1'b0, "glitch_10");
        vsample(8'd11, 3, 1'b0, 1'b1, 2'd3, 1'b0, "glitch_11");
        vsample(8'd12, 3, 1'b1, 1'b1, 2'd3, 1'b0, "glitch_12");
        vsample(8'd13, 3, 1'b0, 1'b1, 2'd3, 1'b0, "glitch_13");
        vsample(8'd14, 3, 1'b1, 1'b1, 2'd3, 1'b0, "glitch_14");
        vsample(8'd15, 3, 1'b0, 1'b1, 2'd3, 1'b0, "glitch_15");

        // Two consecutive misses drop lock; sel holds 3.
        vsample(8'd16, 3, 1'b1, 1'b1, 2'd3, 1'b0, "loss_16");
        vsample(8'd17, 3, 1'b1, 1'b0, 2'd3, 1'b1, "loss_17");

        // Prime history with 0x33 while q mismatches, then all taps match
        // together: the tie must resolve to tap 0.
        for (int i = 1; i <= 3; i++)
            vsample(8'h33, 3, 1'b1, 1'b0, 2'd3, 1'b0, $sformatf("tie_pre%0d", i));
        for (int i = 1; i <= 5; i++)
            vsample(8'h33, 0, 1'b0, (i >= 4), (i >= 4) ? 2'd0 : 2'd3, 1'b0,
                    $sformatf("tie_s%0d", i));

        // Constant data from reset: lock after sample 4 on tap 0.
        do_reset("rst3");
        for (int i = 1; i <= 5; i++)
            vsample(8'hAA, 0, 1'b0, (i >= 4), 2'd0, 1'b0, $sformatf("const_s%0d", i));

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tap_delay_detector.md
# tap_delay_detector

Recovers the tap selection of a tapped 8-bit delay line by watching its input and output streams. The block keeps its own history of the input stream and compares the observed output against every candidate delay from 0 to DEPTH samples. It then reports which delay the line is currently applying and whether that estimate is stable. It sits beside a selectable delay line in the datapath as the self-check / alignment monitor for that line.

## Interface
- WIDTH, 8, data width of both streams
- DEPTH, 3, maximum delay in samples (candidate taps 0..DEPTH)
- LOCK_COUNT, 4, consecutive matching samples required to lock
- LOSS_COUNT, 2, consecutive mismatching samples that drop lock
- SW, $clog2(DEPTH+1), width of sel
- clk  in  1  single clock; all logic on rising edge
- areset  in  1  reset, asynchronous, active-high; clears all state immediately
- valid  in  1  d and q carry a new sample this cycle
- d  in  WIDTH  delay-line input sample
- q  in  WIDTH  delay-line output sample for the same cycle
- locked  out  1  registered; sel is trustworthy
- sel  out  SW  registered; detected delay (0..DEPTH), meaningful only while locked
- lost  out  1  registered one-cycle pulse when lock is dropped

## Operation
- History: h[1..DEPTH] shift on each valid cycle (h[1]<=d, h[k]<=h[k-1]); h[0] is d itself (combinational). Hold when valid=0.
- Fill counter: counts valid samples since reset, saturating at DEPTH. Tap k is eligible only once the fill counter is at least k, i.e. on the (k+1)-th valid sample and later.
- Per-tap match: m[k] = eligible[k] && (q == h[k]).
- Per-tap run counter c[k] (saturates at LOCK_COUNT):
  - valid and m[k]: increment.
  - valid and !m[k]: clear to 0.
  - valid=0: hold.
- FSM, two states:
  - SEARCH (reset state).
    - When any c[k] would reach LOCK_COUNT on this valid sample, go to LOCK.
    - sel <= lowest such k. Ties always resolve to the lowest index; for example, constant data resolves to tap 0.
  - LOCK:
    - Valid sample with m[sel]: clear miss counter.
    - Valid sample with !m[sel]: increment miss counter.
    - When the miss counter reaches LOSS_COUNT: go to SEARCH, clear all c[k] and the miss counter, pulse lost. sel holds its last value.
    - Other taps' counters keep running in LOCK but cause no switch. A new delay is only adopted via LOSS → SEARCH → LOCK.
- valid=0 in any state: no state, counter, or output change. lost is still cleared after its single cycle.
- Reset mid-operation: all registers return to reset values asynchronously. History and fill counter clear, so warm-up restarts.

## Timing
- Reset values:
  - locked=0, sel=0, lost=0.
  - h=0, fill=0, c[k]=0, miss=0.
  - FSM in SEARCH.
- All outputs are registered. Comparison of d/q happens in the cycle they are presented. Result is visible the cycle after the deciding valid edge.
- Lock latency (delay k, matching data from the start): locked rises after the edge of valid sample number k+LOCK_COUNT.
- Loss latency: lost pulses, and locked falls, on the cycle after the LOSS_COUNT-th consecutive mismatching valid sample.
- Samples with valid=0 interleaved between valid samples do not break a run or a miss sequence.
- lost is high for exactly one clock, even if valid is low the following cycle.

## Structure
- Shared package tap_delay_pkg holds:
  - state enum {SEARCH, LOCK}
  - the default constants WIDTH / DEPTH / LOCK_COUNT / LOSS_COUNT
- One natural sub-module: tap_run_counter, instanced DEPTH+1 times. It holds the saturating consecutive-match counter with clear, hold and enable, and takes match, valid and clear inputs.
- History register, fill counter, miss counter, FSM and tie-break priority encoder live in the top module.

## Test plan
- Delay 2, d = 0x01,0x02,0x03,… every cycle, q = d delayed 2 (q=0x00 for the first two samples) → locked rises after sample 6, sel=2, lost never asserted.
- Constant d=q=0xAA → locked after sample 4 with sel=0 (lowest-index tie-break).
- Locked at sel=2, then switch the line to delay 1 with incrementing data:
  - after 2 mismatching samples, lost pulses for one cycle and locked=0;
  - 4 samples later, locked=1 with sel=1.
- Locked at sel=3, inject one corrupted q (0xFF) then resume correct data → miss counter clears, locked stays 1, no lost pulse.
- Delay 1 with valid toggling 1,0,1,0 → lock reached after 5 valid samples (10 cycles); outputs frozen on valid=0 cycles.
- areset asserted mid-run while locked → locked, sel, lost go to 0 immediately. After release, warm-up repeats: delay 3 needs 7 valid samples to relock.
